lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial PRBS checker: the receive end of the Fibonacci LFSR pattern generator.
- Consumes one bit per valid cycle and self-synchronises its local LFSR from the incoming stream.
- Declares lock after a run of correct predictions, then counts bit errors using a flywheel prediction.
- Used on link/loopback test paths; the transmitter serialises generator bit 0 each cycle.

Parameters:
- WIDTH, 16, LFSR length; must match the generator.
- TAPS, 16'hB400, feedback mask; bit i set means state bit i feeds the XOR. Must match the generator.
- LOCK_CNT, 32, consecutive correct predictions required to enter LOCK (1..65535).
- LOSS_ERRS, 8, consecutive errors in LOCK that force a resync (1..255).
- CNT_WIDTH, 32, width of the error counter (and bit counter, if enabled).

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  received serial bit, equal to generator lfsr_reg[0] order
- clr_cnt  in  1  synchronous clear of counters; lock state unaffected
- locked  out  1  registered; high while in LOCK
- err_pulse  out  1  registered; one-cycle pulse per errored bit seen in LOCK
- err_count  out  CNT_WIDTH  saturating error count
- bit_count  out  CNT_WIDTH  bits compared in LOCK (only with LFSR_CHECKER_BER_EN)

Behaviour:
- Reset: rx_reg=0, state=FILL, fill/match/consecutive-error counters=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- Only cycles with in_valid=1 advance anything. With in_valid=0 all state holds and err_pulse=0.
- Prediction: pred = XOR of rx_reg[i] for every i with TAPS[i]=1.
  - rx_reg equals the generator state WIDTH-1 bits behind, so pred is the expected value of the next in_bit.
- Shift: right shift with MSB insert, rx_reg <= {ins, rx_reg[WIDTH-1:1]}.
  - ins = in_bit in FILL and SYNC (self-sync).
  - ins = pred in LOCK (flywheel), so a single line error costs exactly one error count.
- State FILL: shift in WIDTH valid bits and count them. When the WIDTH-th bit is accepted, go to SYNC with match_cnt=0.
- State SYNC, per valid bit:
  - Match (in_bit==pred) with rx_reg!=0: match_cnt++.
  - Mismatch, or rx_reg==0: match_cnt=0. An all-zero register is lock-up; it must never lock on an all-zero stream.
  - On the valid bit where match_cnt reaches LOCK_CNT: go to LOCK and set locked=1 on the next edge.
  - Errors are not counted in SYNC.
- State LOCK, per valid bit:
  - Mismatch: err_pulse=1 next cycle, err_count++ saturating at all-ones, cons_err++.
  - Match: cons_err=0.
  - When cons_err reaches LOSS_ERRS: go to FILL, clear fill_cnt, locked=0 next cycle. That final error is still counted.
- Latency: err_pulse and locked are registered, asserting the cycle after the in_valid beat that causes them.
- clr_cnt:
  - Zeroes err_count and bit_count.
  - If clr_cnt and an error occur in the same cycle, the counter ends at 0; the err_pulse still fires.
- Reset mid-operation: immediate return to the reset values, asynchronously.

Optional Feature:
- Macro LFSR_CHECKER_BER_EN.
- Defined: bit_count port and register exist. bit_count increments (saturating) on every valid bit compared in LOCK, so BER = err_count/bit_count. Cleared by clr_cnt.
- Undefined: no bit_count port or register; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - state enum lfsr_chk_state_t {FILL, SYNC, LOCK}.
  - Default constants LFSR_WIDTH=16, LFSR_TAPS=16'hB400, LFSR_SEED=16'hACE1, shared with the generator.
- Sub-module lfsr_tap_xor (params WIDTH, TAPS; in vec, out parity):
  - Combinational masked XOR.
  - Natural to reuse in the generator for the tap computation.

Test Plan:
- Clean lock: generator (16, B400, seed ACE1) bit 0 streamed with in_valid=1 continuously -> locked rises the cycle after the 48th bit (16 fill + 32 matches); err_count stays 0 over 10000 bits.
- Single error: invert one bit 100 bits after lock -> exactly one err_pulse the next cycle, err_count=1, locked stays 1, no further errors.
- Loss of lock: invert 8 consecutive bits in LOCK -> err_count=8, locked falls after the 8th; the stream then relocks after 48 more clean bits.
- Idle gaps: random in_valid at about 30% duty on a clean stream -> same lock point counted in valid beats; err_pulse never asserted on an in_valid=0 cycle.
- All-zero input: 1000 zero bits -> locked never asserts, err_count=0.
- Counters (BER_EN defined): lock, then 500 clean bits with 3 injected errors -> bit_count=500 (counting from the first post-lock bit), err_count=3. Pulse clr_cnt -> both 0 while locked stays 1. Force err_count near all-ones -> it saturates, no wrap.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } lfsr_chk_state_t;

endpackage

// File: rtl/lfsr_tap_xor.sv
// Masked XOR of an LFSR state: the feedback / next-bit prediction.
module lfsr_tap_xor
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             parity
);

  // Parity of the tapped state bits
  assign parity = ^(vec & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronising receive LFSR with lock detection,
// flywheel prediction in lock and a saturating error counter.
// Optional macro LFSR_CHECKER_BER_EN adds the bit_count port and register.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS),
  parameter int unsigned      LOCK_CNT  = 32,
  parameter int unsigned      LOSS_ERRS = 8,
  parameter int unsigned      CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count
`ifdef LFSR_CHECKER_BER_EN
  ,
  output logic [CNT_WIDTH-1:0] bit_count
`endif
);

  localparam int unsigned FILL_W  = $clog2(WIDTH) + 1;
  localparam int unsigned MATCH_W = 16;
  localparam int unsigned CONS_W  = 8;

  lfsr_chk_state_t        state_q, state_d;
  logic [WIDTH-1:0]       rx_q, rx_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic [CONS_W-1:0]      cons_q, cons_d;
  logic                   locked_d;
  logic                   err_pulse_d;
  logic [CNT_WIDTH-1:0]   err_cnt_d;
`ifdef LFSR_CHECKER_BER_EN
  logic [CNT_WIDTH-1:0]   bit_cnt_d;
`endif
  logic                   pred;
  logic                   mismatch;

  // Expected next input bit from the local register
  lfsr_tap_xor #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pred (
    .vec    (rx_q),
    .parity (pred)
  );

  assign mismatch = in_bit ^ pred;

  // Next-state and counter logic; only valid beats advance anything
  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    fill_d      = fill_q;
    match_d     = match_q;
    cons_d      = cons_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_count;
`ifdef LFSR_CHECKER_BER_EN
    bit_cnt_d   = bit_count;
`endif

    if (in_valid) begin
      case (state_q)
        FILL: begin
          rx_d = {in_bit, rx_q[WIDTH-1:1]};
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            state_d = SYNC;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        SYNC: begin
          rx_d = {in_bit, rx_q[WIDTH-1:1]};
          // An all-zero register predicts zeros forever: never count it
          if (mismatch || (rx_q == '0)) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = LOCK;
            match_d = '0;
            cons_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCK: begin
          // Flywheel: line errors never corrupt the local register
          rx_d = {pred, rx_q[WIDTH-1:1]};
`ifdef LFSR_CHECKER_BER_EN
          if (bit_count != '1) bit_cnt_d = bit_count + CNT_WIDTH'(1);
`endif
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count != '1) err_cnt_d = err_count + CNT_WIDTH'(1);
            if (cons_q == CONS_W'(LOSS_ERRS - 1)) begin
              state_d = FILL;
              fill_d  = '0;
              cons_d  = '0;
            end else begin
              cons_d = cons_q + CONS_W'(1);
            end
          end else begin
            cons_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
`ifdef LFSR_CHECKER_BER_EN
      bit_cnt_d = '0;
`endif
    end

    locked_d = (state_d == LOCK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= FILL;
      rx_q      <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      cons_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef LFSR_CHECKER_BER_EN
      bit_count <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cons_q    <= cons_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_cnt_d;
`ifdef LFSR_CHECKER_BER_EN
      bit_count <= bit_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a main instance plus a narrow-counter
// instance (3-bit counters, lock never dropped) for saturation.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int unsigned CW = 32;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          in_valid;
  logic          in_bit;
  logic          clr_cnt;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic          s_locked;
  logic          s_err_pulse;
  logic [SW-1:0] s_err_count;
`ifdef LFSR_CHECKER_BER_EN
  logic [CW-1:0] bit_count;
  logic [SW-1:0] s_bit_count;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] gen;
  logic        saw_pulse;

  always #5 clk = ~clk;

  lfsr_checker #(
    .WIDTH(16), .TAPS(16'hB400), .LOCK_CNT(32), .LOSS_ERRS(8), .CNT_WIDTH(CW)
  ) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef LFSR_CHECKER_BER_EN
    ,
    .bit_count (bit_count)
`endif
  );

  lfsr_checker #(
    .WIDTH(16), .TAPS(16'hB400), .LOCK_CNT(32), .LOSS_ERRS(255), .CNT_WIDTH(SW)
  ) u_sat (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_cnt   (clr_cnt),
    .locked    (s_locked),
    .err_pulse (s_err_pulse),
    .err_count (s_err_count)
`ifdef LFSR_CHECKER_BER_EN
    ,
    .bit_count (s_bit_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference generator: serialises bit 0, right shift with feedback at MSB
  task automatic next_bit(output logic b);
    b   = gen[0];
    gen = {^(gen & 16'hB400), gen[15:1]};
  endtask

  task automatic beat(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    if (err_pulse) saw_pulse = 1'b1;
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      beat(1'b1, b, 1'b0);
    end
  endtask

  task automatic bad();
    logic b;
    next_bit(b);
    beat(1'b1, ~b, 1'b0);
  endtask

  initial begin
    logic b;
    logic any_lock;
    int   nv;
    int   guard;

    rst_b = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    gen = LFSR_SEED; saw_pulse = 1'b0;
    #3;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", err_count, 32'd0);
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;

    // Clean lock: 16 fill + 32 matches
    clean(47);
    chk("lock_at_47", 32'(locked), 32'd0);
    clean(1);
    chk("lock_at_48", 32'(locked), 32'd1);
    chk("sat_lock_at_48", 32'(s_locked), 32'd1);
    saw_pulse = 1'b0;
    clean(10000 - 48);
    chk("clean_no_pulse", 32'(saw_pulse), 32'd0);
    chk("clean_err_count", err_count, 32'd0);

    // Single error
    bad();
    chk("single_pulse", 32'(err_pulse), 32'd1);
    chk("single_count", err_count, 32'd1);
    chk("single_locked", 32'(locked), 32'd1);
    beat(1'b0, 1'b0, 1'b0);
    chk("idle_no_pulse", 32'(err_pulse), 32'd0);
    saw_pulse = 1'b0;
    clean(100);
    chk("single_no_more", 32'(saw_pulse), 32'd0);
    chk("single_count_hold", err_count, 32'd1);

    // Loss of lock; narrow instance saturates and stays locked
    beat(1'b0, 1'b0, 1'b1);
    chk("clr_err_count", err_count, 32'd0);
    chk("clr_locked", 32'(locked), 32'd1);
    chk("clr_sat_count", 32'(s_err_count), 32'd0);
    repeat (7) bad();
    chk("loss_after_7", 32'(locked), 32'd1);
    bad();
    chk("loss_after_8", 32'(locked), 32'd0);
    chk("loss_err_count", err_count, 32'd8);
    chk("loss_pulse", 32'(err_pulse), 32'd1);
    chk("sat_err_count", 32'(s_err_count), 32'd7);
    chk("sat_locked", 32'(s_locked), 32'd1);
    clean(47);
    chk("relock_at_47", 32'(locked), 32'd0);
    clean(1);
    chk("relock_at_48", 32'(locked), 32'd1);
    chk("relock_err_hold", err_count, 32'd8);

    // Counters: 500 locked bits with 3 errors
    beat(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 500; i++) begin
      if (i == 100 || i == 250 || i == 400) bad();
      else clean(1);
    end
    chk("cnt_err_count", err_count, 32'd3);
`ifdef LFSR_CHECKER_BER_EN
    chk("cnt_bit_count", bit_count, 32'd500);
    chk("sat_bit_count", 32'(s_bit_count), 32'd7);
`endif
    chk("cnt_locked", 32'(locked), 32'd1);
    beat(1'b0, 1'b0, 1'b1);
    chk("cnt_clr_err", err_count, 32'd0);
`ifdef LFSR_CHECKER_BER_EN
    chk("cnt_clr_bit", bit_count, 32'd0);
`endif
    chk("cnt_clr_locked", 32'(locked), 32'd1);
    next_bit(b);
    beat(1'b1, ~b, 1'b1);
    chk("clr_err_same_pulse", 32'(err_pulse), 32'd1);
    chk("clr_err_same_count", err_count, 32'd0);
    bad();
    chk("pre_reset_count", err_count, 32'd1);

    // Asynchronous reset mid-operation
    rst_b = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_count", err_count, 32'd0);
    gen = LFSR_SEED;
    #5; rst_b = 1'b1;
    @(posedge clk); #1;

    // Idle gaps: lock point counted in valid beats only
    nv = 0; guard = 0; saw_pulse = 1'b0;
    while (nv < 47 && guard < 20000) begin
      guard++;
      if ($urandom_range(0, 9) < 3) begin
        next_bit(b);
        beat(1'b1, b, 1'b0);
        nv++;
      end else begin
        beat(1'b0, 1'b0, 1'b0);
      end
    end
    chk("gap_valid_beats", 32'(nv), 32'd47);
    repeat (3) beat(1'b0, 1'b0, 1'b0);
    chk("gap_lock_at_47", 32'(locked), 32'd0);
    clean(1);
    chk("gap_lock_at_48", 32'(locked), 32'd1);
    chk("gap_no_pulse", 32'(saw_pulse), 32'd0);
    bad();
    chk("gap_err_pulse", 32'(err_pulse), 32'd1);
    beat(1'b0, 1'b0, 1'b0);
    chk("gap_idle_pulse", 32'(err_pulse), 32'd0);
    chk("gap_err_count", err_count, 32'd1);

    // All-zero input never locks
    rst_b = 1'b0;
    #5; rst_b = 1'b1;
    @(posedge clk); #1;
    any_lock = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      if (locked) any_lock = 1'b1;
    end
    chk("zero_never_lock", 32'(any_lock), 32'd0);
    chk("zero_err_count", err_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
